mips_regfile_mp: RTL

// - Parametrised multi-port GPR file for the MIPS datapath; successor of the 2R/1W register file.
// - Provides NREAD async read ports and NWRITE sync write ports, with register 0 hardwired to zero.
// - Adds optional write-to-read bypass and a post-reset clear sweep that zeroes the array one entry per cycle.
// - Sits between decode (read ports) and writeback (write ports). Multi-cycle and dual-issue variants share this block.

---
 rtl/mips_pkg.sv | 18 +
 rtl/rf_read_port.sv | 52 +++++
 rtl/mips_regfile_mp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared constants and types for the MIPS register-file blocks
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam int REG_ZERO       = 0;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// rf_read_port : one asynchronous read mux with zero-detect and write bypass
// Rev 1.0
// ============================================================================
module rf_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1
) (
  input  logic                            run,
  input  logic [ADDR_W-1:0]               raddr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   mem_flat,
  input  logic [NWRITE-1:0]               wen,
  input  logic [NWRITE*ADDR_W-1:0]        waddr,
  input  logic [NWRITE*DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]               rdata
);

  logic              w_hit;
  logic [DATA_W-1:0] w_byp;
  logic [DATA_W-1:0] w_word;

  // Ascending scan: the highest-numbered matching write port wins.
  always_comb begin
    w_hit = 1'b0;
    w_byp = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr)) begin
        w_hit = 1'b1;
        w_byp = wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_word = mem_flat[raddr*DATA_W +: DATA_W];
    if ((BYPASS != 0) && w_hit) begin
      w_word = w_byp;
    end
    if (!run || (raddr == ADDR_W'(REG_ZERO))) begin
      rdata = '0;
    end else begin
      rdata = w_word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// mips_regfile_mp : multi-port GPR file, r0 hardwired to zero, post-reset sweep
// Rev 1.0
// ============================================================================
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;

  logic [DATA_W-1:0] r_mem  [1:DEPTH-1];
  logic              w_we   [1:DEPTH-1];
  logic [DATA_W-1:0] w_wd   [1:DEPTH-1];
  logic [DEPTH*DATA_W-1:0] w_mem_flat;
  logic              w_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= c_ONE;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_ptr == c_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + c_ONE;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_ptr <= c_ONE;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign w_run = (r_state == RUN);
  assign ready = r_ready;

  // Per-entry write decode; scanning ports upward lets port 1 win a conflict.
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      w_we[i] = 1'b0;
      w_wd[i] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
          w_we[i] = 1'b1;
          w_wd[i] = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage carries no reset so it can map onto LUTRAM or plain flops.
  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (r_state == CLEAR) begin
        if (r_clr_ptr == ADDR_W'(i)) begin
          r_mem[i] <= '0;
        end
      end else if (w_we[i]) begin
        r_mem[i] <= w_wd[i];
      end
    end
  end

  always_comb begin
    w_mem_flat = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_mem_flat[i*DATA_W +: DATA_W] = r_mem[i];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWRITE (NWRITE),
      .BYPASS (BYPASS)
    ) u_rd (
      .run      (w_run),
      .raddr    (raddr[k*ADDR_W +: ADDR_W]),
      .mem_flat (w_mem_flat),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule
`default_nettype wire
